// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit owning the architectural HI/LO registers.
//
// MULT/MULTU/MTHI/MTLO commit in a single cycle. DIV/DIVU run a 32-step
// restoring divider. stallreq_o stays high until the result is ready.
// MFHI/MFLO values are returned on result_o.
//
// Ports:
//   clk         clock, all state updates on posedge
//   rst         asynchronous active-low reset
//   aluop_i     operation code from id_ex
//   reg1_i      rs operand: dividend, multiplicand, MTHI/MTLO data
//   reg2_i      rt operand: divisor, multiplier
//   stall_i     pipeline stall vector; bit 3 holds the EX stage
//   flush_i     exception flush; aborts any divide in progress
//   stallreq_o  asks ctrl to hold IF..EX while a divide is in progress
//   result_o    HI for MFHI, LO for MFLO, otherwise 0
//   hi_o, lo_o  current HI/LO registers
module ex_muldiv #(
  parameter logic [7:0] OP_MULT  = 8'b00011000,
  parameter logic [7:0] OP_MULTU = 8'b00011001,
  parameter logic [7:0] OP_DIV   = 8'b00011010,
  parameter logic [7:0] OP_DIVU  = 8'b00011011,
  parameter logic [7:0] OP_MFHI  = 8'b00010000,
  parameter logic [7:0] OP_MTHI  = 8'b00010001,
  parameter logic [7:0] OP_MFLO  = 8'b00010010,
  parameter logic [7:0] OP_MTLO  = 8'b00010011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  output logic        stallreq_o,
  output logic [31:0] result_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic        negq_q, negq_d, negr_q, negr_d;

  logic        is_div, is_sdiv;
  logic [31:0] abs1, abs2;
  logic [63:0] prod_s, prod_u;
  logic [32:0] partial;
  logic [33:0] diff;
  logic [31:0] quo_fix, rem_fix;

  assign is_div  = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
  assign is_sdiv = (aluop_i == OP_DIV);
  assign abs1    = (is_sdiv && reg1_i[31]) ? (~reg1_i + 32'd1) : reg1_i;
  assign abs2    = (is_sdiv && reg2_i[31]) ? (~reg2_i + 32'd1) : reg2_i;

  assign prod_s = $signed({{32{reg1_i[31]}}, reg1_i}) * $signed({{32{reg2_i[31]}}, reg2_i});
  assign prod_u = {32'd0, reg1_i} * {32'd0, reg2_i};

  // Restoring step: shift remainder:quotient left and trial-subtract the divisor.
  // The remainder is always below the divisor, so the shifted value fits in 33 bits.
  assign partial = {rem_q, quo_q[31]};
  assign diff    = {1'b0, partial} - {2'b00, dvs_q};

  assign quo_fix = negq_q ? (~quo_q + 32'd1) : quo_q;
  assign rem_fix = negr_q ? (~rem_q + 32'd1) : rem_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;

    if (!stall_i[3]) begin
      if (aluop_i == OP_MULT) begin
        {hi_d, lo_d} = prod_s;
      end else if (aluop_i == OP_MULTU) begin
        {hi_d, lo_d} = prod_u;
      end else if (aluop_i == OP_MTHI) begin
        hi_d = reg1_i;
      end else if (aluop_i == OP_MTLO) begin
        lo_d = reg1_i;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (is_div) begin
          if (reg2_i == 32'd0) begin
            // Divide by zero: raw results, no sign fix, skip the iterations.
            quo_d   = 32'hFFFF_FFFF;
            rem_d   = reg1_i;
            negq_d  = 1'b0;
            negr_d  = 1'b0;
            state_d = StDone;
          end else begin
            rem_d   = 32'd0;
            quo_d   = abs1;
            dvs_d   = abs2;
            negq_d  = is_sdiv && (reg1_i[31] ^ reg2_i[31]);
            negr_d  = is_sdiv && reg1_i[31];
            cnt_d   = 5'd0;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (!is_div) begin
          state_d = StIdle;
        end else begin
          if (!diff[33]) begin
            rem_d = diff[31:0];
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = partial[31:0];
            quo_d = {quo_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = StDone;
        end
      end
      StDone: begin
        if (!is_div) begin
          state_d = StIdle;
        end else if (!stall_i[3]) begin
          lo_d    = quo_fix;
          hi_d    = rem_fix;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush_i) begin
      state_d = StIdle;
      cnt_d   = 5'd0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  // Gated by rst so the request drops as soon as reset asserts.
  assign stallreq_o = rst && is_div && (state_q != StDone);
  assign result_o   = (aluop_i == OP_MFHI) ? hi_q :
                      (aluop_i == OP_MFLO) ? lo_q : 32'd0;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_MULT  = 8'b00011000;
  localparam logic [7:0] OP_MULTU = 8'b00011001;
  localparam logic [7:0] OP_DIV   = 8'b00011010;
  localparam logic [7:0] OP_DIVU  = 8'b00011011;
  localparam logic [7:0] OP_MFHI  = 8'b00010000;
  localparam logic [7:0] OP_MTHI  = 8'b00010001;
  localparam logic [7:0] OP_MFLO  = 8'b00010010;
  localparam logic [7:0] OP_MTLO  = 8'b00010011;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop;
  logic [31:0] reg1, reg2;
  logic [5:0]  stall;
  logic        flush;
  logic        stallreq;
  logic [31:0] result, hi, lo;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  ex_muldiv dut (
    .clk       (clk),
    .rst       (rst),
    .aluop_i   (aluop),
    .reg1_i    (reg1),
    .reg2_i    (reg2),
    .stall_i   (stall),
    .flush_i   (flush),
    .stallreq_o(stallreq),
    .result_o  (result),
    .hi_o      (hi),
    .lo_o      (lo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count stall-request cycles (bounded), let the DONE commit happen, then retire the op.
  task automatic wait_stall(output int cnt);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!stallreq) break;
      cnt++;
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    aluop = OP_NOP;
    #1;
  endtask

  task automatic do_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cnt);
    aluop = op;
    reg1  = a;
    reg2  = b;
    wait_stall(cnt);
  endtask

  initial begin
    rst   = 1'b0;
    aluop = OP_NOP;
    reg1  = 32'd0;
    reg2  = 32'd0;
    stall = 6'd0;
    flush = 1'b0;
    #2;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_stallreq", stallreq, 32'd0);
    chk("rst_result", result, 32'd0);
    #10;
    rst = 1'b1;
    tick();

    // Multiply, signed and unsigned
    aluop = OP_MULT;
    reg1  = 32'hFFFF_FFFE;
    reg2  = 32'h0000_0003;
    tick();
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    aluop = OP_MULTU;
    tick();
    chk("multu_hi", hi, 32'h0000_0002);
    chk("multu_lo", lo, 32'hFFFF_FFFA);
    aluop = OP_MFLO;
    #1;
    chk("mflo_result", result, 32'hFFFF_FFFA);
    aluop = OP_MFHI;
    #1;
    chk("mfhi_result", result, 32'h0000_0002);
    aluop = OP_NOP;
    #1;
    chk("nop_result", result, 32'd0);

    // Signed divide -7 / 2
    do_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, n);
    chk("div_stall_cycles", n, 32'd33);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // Unsigned divide 100 / 7
    do_div(OP_DIVU, 32'd100, 32'd7, n);
    chk("divu_stall_cycles", n, 32'd33);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    // Divide by zero, with the DONE commit held off by an EX stall for one cycle
    aluop = OP_DIVU;
    reg1  = 32'd5;
    reg2  = 32'd0;
    #1;
    chk("div0_stallreq_first", stallreq, 32'd1);
    stall = 6'b001000;
    tick();
    chk("div0_stallreq_done", stallreq, 32'd0);
    tick();
    chk("div0_held_lo", lo, 32'd14);
    stall = 6'd0;
    tick();
    aluop = OP_NOP;
    #1;
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    chk("div0_hi", hi, 32'd5);

    // Signed overflow corner
    do_div(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
    chk("ovf_stall_cycles", n, 32'd33);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'd0);

    // Flush at RUN cnt=12: HI/LO untouched, divide restarts from scratch
    aluop = OP_DIV;
    reg1  = 32'd50;
    reg2  = 32'd3;
    repeat (13) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_hi", hi, 32'd0);
    chk("flush_lo", lo, 32'h8000_0000);
    wait_stall(n);
    chk("flush_restart_cycles", n, 32'd33);
    chk("flush_restart_lo", lo, 32'd16);
    chk("flush_restart_hi", hi, 32'd2);
    aluop = OP_DIV;
    repeat (5) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    aluop = OP_NOP;
    #1;
    chk("flush_stallreq", stallreq, 32'd0);
    chk("flush2_lo", lo, 32'd16);

    // Reset in the middle of a divide
    aluop = OP_MTHI;
    reg1  = 32'h0000_AAAA;
    tick();
    aluop = OP_MTLO;
    reg1  = 32'h0000_5555;
    tick();
    chk("pre_rst_hi", hi, 32'h0000_AAAA);
    aluop = OP_DIV;
    reg1  = 32'd1000;
    reg2  = 32'd7;
    repeat (10) tick();
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    chk("midrst_stallreq", stallreq, 32'd0);
    #3;
    rst = 1'b1;
    wait_stall(n);
    chk("postrst_stall_cycles", n, 32'd33);
    chk("postrst_lo", lo, 32'd142);
    chk("postrst_hi", hi, 32'd6);

    // MTHI under an EX stall, then released, then read back
    aluop = OP_MTHI;
    reg1  = 32'h0000_1234;
    stall = 6'b001000;
    tick();
    chk("mthi_stalled_hi", hi, 32'd6);
    stall = 6'd0;
    tick();
    chk("mthi_hi", hi, 32'h0000_1234);
    aluop = OP_MFHI;
    reg1  = 32'd0;
    tick();
    chk("mfhi_after_mthi", result, 32'h0000_1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
